// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: freezes, flushes and bubbles for a 5-stage pipe with memory-timeout error trap.
// Latency: control outputs are combinational from state and inputs; state and counters update on the next edge.
// Backpressure: a memory wait freezes the whole pipe and outranks branch flushes, which in turn outrank hazard stalls.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             clear_error,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             flush_if_id,
    output logic             bubble_exe,
    output logic             bubble_wb,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [7:0]       flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [7:0]       flush_count_q, flush_count_d;

    logic in_error;
    logic mem_stall;
    logic hazard_stall;
    logic br_flush;

    // ERROR masks every stall source so the pipe stays fully frozen and nothing is flushed
    assign in_error     = (state_q == ERROR);
    assign mem_stall    = ~in_error & mem_req & ~sram_ready;
    assign br_flush     = ~in_error & branch_taken & ~mem_stall;
    assign hazard_stall = ~in_error & hazard & ~branch_taken & ~mem_stall;

    assign freeze_if    = in_error | mem_stall | hazard_stall;
    assign freeze_id    = in_error | mem_stall | hazard_stall;
    assign freeze_exe   = in_error | mem_stall;
    assign freeze_mem   = in_error | mem_stall;
    assign bubble_wb    = mem_stall;
    assign bubble_exe   = hazard_stall | br_flush;
    assign flush_if_id  = br_flush;
    assign mem_error    = mem_error_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_error_d    = mem_error_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT) begin
                    state_d     = ERROR;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERROR: begin
                if (clear_error) begin
                    state_d     = RUN;
                    wait_cnt_d  = 8'd0;
                    mem_error_d = 1'b0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase

        if (freeze_if && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (br_flush && (flush_count_q != 8'hFF))
            flush_count_d = flush_count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            mem_error_q    <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_error_q    <= mem_error_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed vector table, multi-cycle corner sequences and random stimulus
// compared against a behavioural model that tracks consecutive memory-wait cycles and saturating counts.
module tb_pipeline_stall_controller;

    localparam int T    = 4;
    localparam int CW   = 8;
    localparam int SMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hazard = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, sram_ready = 1'b0, clear_error = 1'b0;
    logic freeze_if, freeze_id, freeze_exe, freeze_mem;
    logic flush_if_id, bubble_exe, bubble_wb, mem_error;
    logic [CW-1:0] stall_cycles;
    logic [7:0]    flush_count;

    pipeline_stall_controller #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready), .clear_error(clear_error),
        .freeze_if(freeze_if), .freeze_id(freeze_id), .freeze_exe(freeze_exe), .freeze_mem(freeze_mem),
        .flush_if_id(flush_if_id), .bubble_exe(bubble_exe), .bubble_wb(bubble_wb),
        .mem_error(mem_error), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: error flag, count of consecutive memory-wait cycles, saturating counters
    bit m_err;
    int m_consec, m_stall, m_flush;
    bit e_ms, e_flush, e_hz, e_fif, e_fexe, e_bexe, e_bwb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_consec = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_comb();
        e_ms    = !m_err && mem_req && !sram_ready;
        e_flush = !m_err && branch_taken && !e_ms;
        e_hz    = !m_err && hazard && !branch_taken && !e_ms;
        e_fif   = m_err || e_ms || e_hz;
        e_fexe  = m_err || e_ms;
        e_bexe  = e_hz || e_flush;
        e_bwb   = e_ms;
    endtask

    task automatic model_check(input string tag);
        model_comb();
        chk({tag, ".freeze_if"},    32'(freeze_if),    32'(e_fif));
        chk({tag, ".freeze_id"},    32'(freeze_id),    32'(e_fif));
        chk({tag, ".freeze_exe"},   32'(freeze_exe),   32'(e_fexe));
        chk({tag, ".freeze_mem"},   32'(freeze_mem),   32'(e_fexe));
        chk({tag, ".flush_if_id"},  32'(flush_if_id),  32'(e_flush));
        chk({tag, ".bubble_exe"},   32'(bubble_exe),   32'(e_bexe));
        chk({tag, ".bubble_wb"},    32'(bubble_wb),    32'(e_bwb));
        chk({tag, ".mem_error"},    32'(mem_error),    32'(m_err));
        chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        chk({tag, ".flush_count"},  32'(flush_count),  32'(m_flush));
    endtask

    // Error fires on the (T+1)th consecutive memory-wait cycle unless the access completes
    task automatic model_update();
        if (m_err) begin
            if (clear_error) begin m_err = 0; m_consec = 0; end
        end else if (e_ms) begin
            m_consec++;
            if (m_consec > T) m_err = 1;
        end else begin
            m_consec = 0;
        end
        if (e_fif && m_stall < SMAX) m_stall++;
        if (e_flush && m_flush < 255) m_flush++;
    endtask

    task automatic step(input string tag, input bit h, input bit b, input bit m, input bit r, input bit c);
        @(negedge clk);
        hazard = h; branch_taken = b; mem_req = m; sram_ready = r; clear_error = c;
        #1;
        model_check(tag);
        model_update();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit h, b, m, r, c;
        bit fif, fexe, flush, bexe, bwb, err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // {hazard, branch, mem_req, ready, clear} -> {freeze_if, freeze_exe, flush_if_id, bubble_exe, bubble_wb, mem_error}
        vecs[0] = '{1,0,0,0,0, 1,0,0,1,0,0};
        vecs[1] = '{1,0,0,0,0, 1,0,0,1,0,0};
        vecs[2] = '{0,0,0,0,0, 0,0,0,0,0,0};
        vecs[3] = '{1,1,0,0,0, 0,0,1,1,0,0};
        vecs[4] = '{0,0,1,0,0, 1,1,0,0,1,0};
        vecs[5] = '{0,0,1,0,0, 1,1,0,0,1,0};
        vecs[6] = '{0,0,1,0,0, 1,1,0,0,1,0};
        vecs[7] = '{0,0,1,1,0, 0,0,0,0,0,0};
        vecs[8] = '{1,1,1,0,0, 1,1,0,0,1,0};
        vecs[9] = '{0,0,0,0,1, 0,0,0,0,0,0};

        // Outputs must be purely input-driven while reset is held
        model_reset();
        mem_req = 1'b1; sram_ready = 1'b0; #1;
        chk("rst_hold.freeze_exe", 32'(freeze_exe), 32'd1);
        chk("rst_hold.stall_cycles", 32'(stall_cycles), 32'd0);
        mem_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), vecs[i].h, vecs[i].b, vecs[i].m, vecs[i].r, vecs[i].c);
            chk($sformatf("vec%0d.tbl_fif", i),   32'(freeze_if),   32'(vecs[i].fif));
            chk($sformatf("vec%0d.tbl_fexe", i),  32'(freeze_exe),  32'(vecs[i].fexe));
            chk($sformatf("vec%0d.tbl_flush", i), 32'(flush_if_id), 32'(vecs[i].flush));
            chk($sformatf("vec%0d.tbl_bexe", i),  32'(bubble_exe),  32'(vecs[i].bexe));
            chk($sformatf("vec%0d.tbl_bwb", i),   32'(bubble_wb),   32'(vecs[i].bwb));
            chk($sformatf("vec%0d.tbl_err", i),   32'(mem_error),   32'(vecs[i].err));
            if (i == 2) chk("hazard2.stall_cycles", 32'(stall_cycles), 32'd2);
            if (i == 4) chk("branch.flush_count", 32'(flush_count), 32'd1);
        end
        chk("table.stall_cycles", 32'(stall_cycles), 32'd6);

        // Timeout: five consecutive waits enter ERROR, which holds freezes until cleared
        do_reset();
        for (int i = 0; i < T + 1; i++) step("tmo_wait", 0, 0, 1, 0, 0);
        step("tmo_err", 1, 1, 0, 1, 0);
        chk("tmo.mem_error", 32'(mem_error), 32'd1);
        chk("tmo.freeze_mem", 32'(freeze_mem), 32'd1);
        chk("tmo.flush_if_id", 32'(flush_if_id), 32'd0);
        step("tmo_clr", 0, 0, 1, 0, 1);
        step("tmo_run", 0, 0, 0, 0, 0);
        chk("tmo_clr.mem_error", 32'(mem_error), 32'd0);
        chk("tmo_clr.freeze_if", 32'(freeze_if), 32'd0);

        // Completion exactly at the timeout boundary is a normal return to RUN
        for (int i = 0; i < T; i++) step("edge_wait", 0, 0, 1, 0, 0);
        step("edge_done", 0, 0, 1, 1, 0);
        step("edge_after", 0, 0, 1, 0, 0);
        chk("edge.mem_error", 32'(mem_error), 32'd0);
        step("edge_idle", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-wait with stall_cycles at 7
        do_reset();
        for (int i = 0; i < 4; i++) step("pre_rst_hz", 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("pre_rst_mw", 0, 0, 1, 0, 0);
        @(negedge clk);
        hazard = 0; branch_taken = 0; mem_req = 1; sram_ready = 0; #1;
        chk("pre_rst.stall_cycles", 32'(stall_cycles), 32'd7);
        #1 mem_req = 0; rst_n = 1'b0; #1;
        model_reset();
        chk("async_rst.stall_cycles", 32'(stall_cycles), 32'd0);
        chk("async_rst.freeze_if", 32'(freeze_if), 32'd0);
        chk("async_rst.freeze_exe", 32'(freeze_exe), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter saturation
        do_reset();
        for (int i = 0; i < SMAX + 4; i++) step("sat_hz", 1, 0, 0, 0, 0);
        step("sat_idle", 0, 0, 0, 0, 0);
        chk("sat.stall_cycles", 32'(stall_cycles), 32'(SMAX));
        for (int i = 0; i < 260; i++) step("sat_br", 0, 1, 0, 0, 0);
        step("sat_idle2", 0, 0, 0, 0, 0);
        chk("sat.flush_count", 32'(flush_count), 32'd255);

        // Random traffic biased toward long memory waits
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 15: the number of consecutive memory-wait cycles after which the block enters ERROR (range 1..255).
REQ-002 SHALL provide parameter CNT_W, default 16: the width of the stall-cycle performance counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port hazard, input, 1, data hazard flag from the hazard detection unit.
REQ-006 SHALL have port branch_taken, input, 1, branch resolved taken in EXE this cycle.
REQ-007 SHALL have port mem_req, input, 1, MEM stage is issuing a read or write this cycle.
REQ-008 SHALL have port sram_ready, input, 1, memory completes the current access this cycle.
REQ-009 SHALL have port clear_error, input, 1, synchronous request to leave ERROR.
REQ-010 SHALL have ports freeze_if, freeze_id, freeze_exe, freeze_mem, output, 1 each, hold the corresponding pipeline register.
REQ-011 SHALL have ports flush_if_id, bubble_exe, bubble_wb, output, 1 each: clear IF/ID, insert a NOP into ID/EXE, insert a NOP into MEM/WB.
REQ-012 SHALL have port mem_error, output, 1, sticky memory-timeout indication.
REQ-013 SHALL have port stall_cycles, output, CNT_W, saturating count of cycles with freeze_if=1.
REQ-014 SHALL have port flush_count, output, 8, saturating count of branch flushes.

Function
REQ-015 SHALL implement a state machine with states RUN, MEM_WAIT and ERROR, and a wait counter wait_cnt of 8 bits.
REQ-016 SHALL compute mem_stall = mem_req & ~sram_ready when the state is RUN or MEM_WAIT; mem_stall SHALL be 0 in ERROR.
REQ-017 SHALL compute hazard_stall = hazard & ~branch_taken & ~mem_stall, and br_flush = branch_taken & ~mem_stall.
REQ-018 In RUN and MEM_WAIT, the outputs SHALL be combinational in the same cycle: freeze_if = freeze_id = mem_stall | hazard_stall; freeze_exe = freeze_mem = bubble_wb = mem_stall; bubble_exe = hazard_stall | br_flush; flush_if_id = br_flush.
REQ-019 Priority SHALL be mem_stall > branch_taken > hazard: a branch during a memory wait is not flushed (EXE is frozen, so the branch re-presents), and a branch overrides a hazard stall.
REQ-020 Transition RUN->MEM_WAIT SHALL occur when mem_stall=1, with wait_cnt set to 1.
REQ-021 In MEM_WAIT, when mem_stall=1, wait_cnt SHALL increment; when sram_ready=1 or mem_req=0, the state SHALL return to RUN and wait_cnt SHALL clear.
REQ-022 When mem_stall=1 and wait_cnt == MEM_TIMEOUT, the next state SHALL be ERROR and mem_error SHALL be set to 1.
REQ-023 In ERROR, all four freeze outputs SHALL be 1, and flush_if_id, bubble_exe and bubble_wb SHALL be 0, regardless of the inputs.
REQ-024 In ERROR, clear_error=1 SHALL return the state to RUN on the next edge and clear mem_error and wait_cnt; clear_error SHALL be ignored in other states.
REQ-025 stall_cycles SHALL increment each cycle freeze_if=1, including ERROR cycles, and SHALL hold at all-ones without wrapping.
REQ-026 flush_count SHALL increment each cycle br_flush=1 and SHALL saturate at 255.
REQ-027 Simultaneous sram_ready=1 and wait_cnt == MEM_TIMEOUT SHALL complete the access normally, with a return to RUN and no error.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force the state to RUN and clear wait_cnt, mem_error, stall_cycles and flush_count, in any state including mid-wait.
REQ-029 While rst_n=0, all freeze and flush outputs SHALL follow REQ-018 using the reset state, so they depend only on the inputs.
REQ-030 After rst_n is released, the first state update SHALL occur on the next rising clk edge.

Verification
REQ-031 Apply hazard=1 for 2 cycles, all other inputs 0 -> freeze_if=freeze_id=bubble_exe=1 for both cycles; freeze_exe=0; stall_cycles=2.
REQ-032 Apply hazard=1 and branch_taken=1 in the same cycle -> flush_if_id=1, bubble_exe=1, freeze_if=0; flush_count=1.
REQ-033 Apply mem_req=1 with sram_ready=0 for 3 cycles, then sram_ready=1 -> all freezes and bubble_wb=1 for 3 cycles; state returns to RUN; mem_error=0.
REQ-034 With MEM_TIMEOUT=4, hold mem_req=1 and sram_ready=0 -> ERROR entered after the 5th stall cycle, mem_error=1, freezes stay 1; then clear_error=1 -> RUN, mem_error=0.
REQ-035 Assert rst_n=0 mid-MEM_WAIT with stall_cycles=7 -> stall_cycles=0 and state RUN immediately, without a clock edge.
REQ-036 Hold hazard=1 for 2^CNT_W+3 cycles -> stall_cycles saturates at all-ones.
